// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the initiator arbiter: cycle-type codes,
// the per-initiator request bundle and the arbiter state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } wb_req_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Initiator ports plus the shared decoder-facing bus of the arbiter.
// The slave modport is the arbiter's view; master is the initiators/decoder view.
interface wb_arbiter_if #(
  parameter int unsigned N_MASTERS = 2
) ();

  logic [N_MASTERS-1:0]       M_CYC;
  logic [N_MASTERS-1:0]       M_STB;
  logic [N_MASTERS-1:0]       M_WE;
  logic [N_MASTERS-1:0][31:0] M_ADR;
  logic [N_MASTERS-1:0][31:0] M_DAT_O;
  logic [N_MASTERS-1:0][2:0]  M_CTI_O;
  logic [31:0]                M_DAT_I;
  logic [N_MASTERS-1:0]       M_ACK;
  logic [N_MASTERS-1:0]       M_ERR;
  logic [N_MASTERS-1:0]       M_RTY;

  logic        CYC;
  logic        STB;
  logic        WE;
  logic [31:0] ADR;
  logic [31:0] DAT_O;
  logic [2:0]  CTI_O;
  logic [31:0] DAT_I;
  logic        ACK;
  logic        ERR;
  logic        RTY;

  modport slave (
    input  M_CYC, M_STB, M_WE, M_ADR, M_DAT_O, M_CTI_O,
    output M_DAT_I, M_ACK, M_ERR, M_RTY,
    output CYC, STB, WE, ADR, DAT_O, CTI_O,
    input  DAT_I, ACK, ERR, RTY
  );

  modport master (
    output M_CYC, M_STB, M_WE, M_ADR, M_DAT_O, M_CTI_O,
    input  M_DAT_I, M_ACK, M_ERR, M_RTY,
    input  CYC, STB, WE, ADR, DAT_O, CTI_O,
    output DAT_I, ACK, ERR, RTY
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first requester above last_i, with wrap.
module wb_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan farthest candidate first so the nearest one after last_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = N; i > 0; i--) begin
      cand = IW'((32'(last_i) + i) % N);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone initiator arbiter; grant held for the whole CYC,
// with a watchdog that ends stalled strobes with a one-cycle ERR.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave wb
);

  localparam int unsigned    IW   = $clog2(N_MASTERS);
  localparam int unsigned    CW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  wb_req_t       sel;
  logic          stb_eff;

  wb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req_i   (wb.M_CYC),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel.cyc = wb.M_CYC[grant_q];
    sel.stb = wb.M_STB[grant_q];
    sel.we  = wb.M_WE[grant_q];
    sel.adr = wb.M_ADR[grant_q];
    sel.dat = wb.M_DAT_O[grant_q];
    sel.cti = wb.M_CTI_O[grant_q];
  end

  // The watchdog ERR cycle withholds the strobe from the decoder.
  assign stb_eff = sel.stb & ~to_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    to_d       = 1'b0;
    wb.CYC     = 1'b0;
    wb.STB     = 1'b0;
    wb.WE      = 1'b0;
    wb.ADR     = '0;
    wb.DAT_O   = '0;
    wb.CTI_O   = '0;
    wb.M_ACK   = '0;
    wb.M_ERR   = '0;
    wb.M_RTY   = '0;
    wb.M_DAT_I = wb.DAT_I;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_idx;
        end
      end
      BUSY: begin
        wb.CYC   = sel.cyc;
        wb.STB   = stb_eff;
        wb.WE    = sel.we;
        wb.ADR   = sel.adr;
        wb.DAT_O = sel.dat;
        wb.CTI_O = sel.cti;

        // Decoder may raise ERR without a strobe, so gate on the master's STB.
        if (stb_eff) begin
          wb.M_ACK[grant_q] = wb.ACK;
          wb.M_ERR[grant_q] = wb.ERR;
          wb.M_RTY[grant_q] = wb.RTY;
        end
        if (to_q) begin
          wb.M_ERR[grant_q] = 1'b1;
        end

        if (TIMEOUT != 0) begin
          if (!stb_eff || wb.ACK || wb.ERR || wb.RTY) begin
            cnt_d = '0;
          end else if (cnt_q == TMAX) begin
            cnt_d = '0;
            to_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        if (!sel.cyc) begin
          state_d = IDLE;
          last_d  = grant_q;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus hand-written
// sequences for burst atomicity, watchdog timeout and mid-transfer reset.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned TO = 4;
  localparam logic [31:0] A0 = 32'h0000_1100;
  localparam logic [31:0] A1 = 32'h0000_1400;
  localparam logic [31:0] AU = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  wb_arbiter_if #(.N_MASTERS(NM)) wb ();

  wb_arbiter #(.N_MASTERS(NM), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [31:0] a0;
    logic        ack;
    logic        err;
    logic        e_cyc;
    logic        e_stb;
    logic [31:0] e_adr;
    logic [1:0]  e_ack;
    logic [1:0]  e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb,
                              input logic [31:0] a0, input logic ack, input logic err,
                              input logic e_cyc, input logic e_stb, input logic [31:0] e_adr,
                              input logic [1:0] e_ack, input logic [1:0] e_err);
    vec_t v;
    v.cyc = cyc;  v.stb = stb;  v.a0 = a0;  v.ack = ack;  v.err = err;
    v.e_cyc = e_cyc;  v.e_stb = e_stb;  v.e_adr = e_adr;
    v.e_ack = e_ack;  v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_err;

    wb.M_CYC = '0;  wb.M_STB = '0;  wb.M_WE = 2'b01;
    wb.M_ADR[0] = A0;  wb.M_ADR[1] = A1;
    wb.M_DAT_O[0] = 32'hA0A0_0000;  wb.M_DAT_O[1] = 32'hB1B1_0001;
    wb.M_CTI_O[0] = CTI_CLASSIC;  wb.M_CTI_O[1] = CTI_CLASSIC;
    wb.DAT_I = '0;  wb.ACK = 1'b0;  wb.ERR = 1'b0;  wb.RTY = 1'b0;

    // Round-robin, both masters requesting: grants 0,1,0,1 with one idle cycle between.
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b1, 1'b0, 1'b1, 1'b1, A0, 2'b01, 2'b00));
    tv.push_back(mk(2'b10, 2'b10, A0, 1'b0, 1'b0, 1'b0, 1'b0, A0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b1, 1'b0, 1'b1, 1'b1, A1, 2'b10, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, A0, 1'b0, 1'b0, 1'b0, 1'b0, A1, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b1, 1'b0, 1'b1, 1'b1, A0, 2'b01, 2'b00));
    tv.push_back(mk(2'b10, 2'b10, A0, 1'b0, 1'b0, 1'b0, 1'b0, A0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b11, 2'b11, A0, 1'b1, 1'b0, 1'b1, 1'b1, A1, 2'b10, 2'b00));
    tv.push_back(mk(2'b00, 2'b00, A0, 1'b0, 1'b0, 1'b0, 1'b0, A1, 2'b00, 2'b00));
    // Single master 0 classic write, responder ACKs two cycles after bus CYC.
    tv.push_back(mk(2'b00, 2'b00, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, A0, 1'b0, 1'b0, 1'b1, 1'b1, A0, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, A0, 1'b0, 1'b0, 1'b1, 1'b1, A0, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, A0, 1'b1, 1'b0, 1'b1, 1'b1, A0, 2'b01, 2'b00));
    tv.push_back(mk(2'b00, 2'b00, A0, 1'b0, 1'b0, 1'b0, 1'b0, A0, 2'b00, 2'b00));
    tv.push_back(mk(2'b00, 2'b00, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    // Unmapped address: decoder ERR is high throughout but must wait for STB.
    tv.push_back(mk(2'b01, 2'b00, AU, 1'b0, 1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b00, AU, 1'b0, 1'b1, 1'b1, 1'b0, AU, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b00, AU, 1'b0, 1'b1, 1'b1, 1'b0, AU, 2'b00, 2'b00));
    tv.push_back(mk(2'b01, 2'b01, AU, 1'b0, 1'b1, 1'b1, 1'b1, AU, 2'b00, 2'b01));
    tv.push_back(mk(2'b00, 2'b00, AU, 1'b0, 1'b1, 1'b0, 1'b0, AU, 2'b00, 2'b00));
    tv.push_back(mk(2'b00, 2'b00, A0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00));

    #1;
    check("reset CYC", 32'(wb.CYC), 32'd0);
    check("reset STB", 32'(wb.STB), 32'd0);
    check("reset M_ACK", 32'(wb.M_ACK), 32'd0);
    check("reset M_ERR", 32'(wb.M_ERR), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      step();
      wb.M_CYC = tv[i].cyc;  wb.M_STB = tv[i].stb;  wb.M_ADR[0] = tv[i].a0;
      wb.ACK = tv[i].ack;  wb.ERR = tv[i].err;
      #1;
      check($sformatf("v%0d CYC", i), 32'(wb.CYC), 32'(tv[i].e_cyc));
      check($sformatf("v%0d STB", i), 32'(wb.STB), 32'(tv[i].e_stb));
      check($sformatf("v%0d ADR", i), wb.ADR, tv[i].e_adr);
      check($sformatf("v%0d M_ACK", i), 32'(wb.M_ACK), 32'(tv[i].e_ack));
      check($sformatf("v%0d M_ERR", i), 32'(wb.M_ERR), 32'(tv[i].e_err));
    end

    // Master 1 burst; master 0 requests mid-burst and must wait for CYC drop.
    step();
    wb.M_CYC = 2'b10;  wb.M_STB = 2'b10;  wb.M_CTI_O[1] = CTI_INCR;  wb.M_ADR[1] = A1;
    wb.ACK = 1'b0;  wb.ERR = 1'b0;
    #1;
    check("burst idle CYC", 32'(wb.CYC), 32'd0);
    for (int b = 0; b < 4; b++) begin
      step();
      wb.M_ADR[1] = A1 + 32'(4 * b);
      wb.M_CTI_O[1] = (b == 3) ? CTI_END : CTI_INCR;
      wb.ACK = 1'b1;
      if (b == 1) begin
        wb.M_CYC[0] = 1'b1;
        wb.M_STB[0] = 1'b1;
      end
      #1;
      check($sformatf("burst%0d CYC", b), 32'(wb.CYC), 32'd1);
      check($sformatf("burst%0d ADR", b), wb.ADR, A1 + 32'(4 * b));
      check($sformatf("burst%0d CTI", b), 32'(wb.CTI_O), (b == 3) ? 32'(CTI_END) : 32'(CTI_INCR));
      check($sformatf("burst%0d M_ACK", b), 32'(wb.M_ACK), 32'b10);
    end
    check("burst WE", 32'(wb.WE), 32'd0);
    check("burst DAT_O", wb.DAT_O, 32'hB1B1_0001);
    step();
    wb.M_CYC[1] = 1'b0;  wb.M_STB[1] = 1'b0;  wb.ACK = 1'b0;  wb.M_CTI_O[1] = CTI_CLASSIC;
    #1;
    check("burst release CYC", 32'(wb.CYC), 32'd0);
    check("burst release M_ACK", 32'(wb.M_ACK), 32'd0);
    step();
    #1;
    check("burst gap CYC", 32'(wb.CYC), 32'd0);
    step();
    wb.ACK = 1'b1;
    #1;
    check("m0 after burst CYC", 32'(wb.CYC), 32'd1);
    check("m0 after burst ADR", wb.ADR, A0);
    check("m0 after burst WE", 32'(wb.WE), 32'd1);
    check("m0 after burst DAT_O", wb.DAT_O, 32'hA0A0_0000);
    check("m0 after burst M_ACK", 32'(wb.M_ACK), 32'b01);
    step();
    wb.M_CYC = 2'b00;  wb.M_STB = 2'b00;  wb.ACK = 1'b0;

    // Silent responder: ERR 5 cycles after STB rises, then again after re-arm.
    step();
    wb.M_CYC = 2'b01;  wb.M_STB = 2'b01;
    #1;
    check("wdog idle CYC", 32'(wb.CYC), 32'd0);
    for (int t = 1; t <= 12; t++) begin
      step();
      exp_err = (t == 6) || (t == 12);
      check($sformatf("wdog%0d CYC", t), 32'(wb.CYC), 32'd1);
      check($sformatf("wdog%0d STB", t), 32'(wb.STB), 32'(!exp_err));
      check($sformatf("wdog%0d M_ERR", t), 32'(wb.M_ERR), exp_err ? 32'b01 : 32'b00);
    end
    step();
    wb.M_CYC = 2'b00;  wb.M_STB = 2'b00;
    #1;
    check("wdog release CYC", 32'(wb.CYC), 32'd0);
    check("wdog release M_ERR", 32'(wb.M_ERR), 32'd0);

    // Reset during a master 1 read; afterwards master 0 must win first.
    step();
    wb.M_CYC = 2'b10;  wb.M_STB = 2'b10;  wb.M_ADR[1] = A1;
    step();
    wb.DAT_I = 32'hCAFE_F00D;
    #1;
    check("rst busy CYC", 32'(wb.CYC), 32'd1);
    check("rst busy ADR", wb.ADR, A1);
    check("rst busy M_DAT_I", wb.M_DAT_I, 32'hCAFE_F00D);
    #2;
    wb.ACK = 1'b1;
    rst = 1'b0;
    #1;
    check("rst asserted CYC", 32'(wb.CYC), 32'd0);
    check("rst asserted STB", 32'(wb.STB), 32'd0);
    check("rst asserted M_ACK", 32'(wb.M_ACK), 32'd0);
    @(posedge clk);
    #3;
    wb.ACK = 1'b0;  wb.M_CYC = 2'b11;  wb.M_STB = 2'b11;
    rst = 1'b1;
    step();
    wb.ACK = 1'b1;
    #1;
    check("post-rst CYC", 32'(wb.CYC), 32'd1);
    check("post-rst ADR", wb.ADR, A0);
    check("post-rst M_ACK", 32'(wb.M_ACK), 32'b01);
    step();
    wb.M_CYC = 2'b00;  wb.M_STB = 2'b00;  wb.ACK = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
